aes256_key_sched_ctrl: RTL and testbench

Sequential AES-256 key scheduler and round-key server for the iterative cipher core. It accepts a 256-bit cipher key through a valid/ready handshake and generates one 128-bit round key per cycle into a 15-entry round-key buffer. The cipher core reads round keys by index with a 1-cycle-latency request/grant port, and may read in any order (encrypt ascending, decrypt descending). It replaces the fully combinational 60-word expansion with a single round-key step unit.

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/aes256_rk_step.sv | 37 +++
 rtl/aes256_key_sched_ctrl.sv | 140 ++++++++++++++
 tb/tb_aes256_key_sched_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and byte/word helpers for the key-schedule controller.
package aes_pkg;

   localparam int NK         = 8;
   localparam int NR         = 14;
   localparam int RK_W       = 128;
   localparam int NUM_RK_256 = 15;

   typedef logic [0:31]     word_t;
   typedef logic [0:RK_W-1] rk_t;

   // Forward S-box, entry x at bits [8x +: 8] (big-endian byte order).
   localparam logic [0:2047] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [10:0] base;
      base = {x, 3'b000};
      return SBOX_TBL[base +: 8];
   endfunction

   // Round constant for key-expansion round i (1..10); 0 outside that range.
   function automatic logic [7:0] rcon(input logic [3:0] i);
      logic [7:0] r;
      case (i)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // Cyclic left rotation of a word by one byte.
   function automatic word_t rotword(input word_t w);
      return {w[8:31], w[0:7]};
   endfunction

endpackage

// File: rtl/aes256_rk_step.sv
// One AES-256 round-key step: given the previous two round keys A and B,
// produce the next round key. Odd steps use SubWord only, even steps use
// RotWord + SubWord + Rcon.
module aes256_rk_step
   import aes_pkg::*;
(
   input  logic [0:127] i_a,
   input  logic [0:127] i_b,
   input  logic         i_odd,
   input  logic [7:0]   i_rcon,
   output logic [0:127] o_rk
);

   word_t w_last;
   word_t w_sel;
   word_t w_sub;
   word_t w_t;
   word_t w_n0;
   word_t w_n1;
   word_t w_n2;
   word_t w_n3;

   assign w_last = i_b[96:127];
   assign w_sel  = i_odd ? w_last : rotword(w_last);
   assign w_sub  = {sbox(w_sel[0:7]), sbox(w_sel[8:15]),
                    sbox(w_sel[16:23]), sbox(w_sel[24:31])};
   assign w_t    = w_sub ^ (i_odd ? 32'h0000_0000 : {i_rcon, 24'h00_0000});

   // Each new word chains off the previous new word, no carries.
   assign w_n0 = i_a[0:31]   ^ w_t;
   assign w_n1 = i_a[32:63]  ^ w_n0;
   assign w_n2 = i_a[64:95]  ^ w_n1;
   assign w_n3 = i_a[96:127] ^ w_n2;

   assign o_rk = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// Sequential AES-256 key scheduler and round-key server. Accepts a 256-bit
// key, generates one round key per cycle into a 15-entry buffer, and serves
// indexed reads with one cycle of latency.
module aes256_key_sched_ctrl
   import aes_pkg::*;
#(
   parameter int NUM_RK = NUM_RK_256,
   parameter int IDX_W  = 4
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                key_valid,
   output logic                key_ready,
   input  logic [0:NK*32-1]    key_in,
   input  logic                rd_req,
   input  logic [IDX_W-1:0]    rd_idx,
   output logic                rd_gnt,
   output logic                rd_valid,
   output logic [0:RK_W-1]     rd_key,
   output logic                rd_err,
   output logic                busy,
   output logic                sched_done
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_EXPAND = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic [IDX_W-1:0] C_NUM_RK = IDX_W'(NUM_RK);
   localparam logic [IDX_W-1:0] C_LAST   = IDX_W'(NR);
   localparam logic [IDX_W-1:0] C_FIRST  = IDX_W'(2);

   logic [1:0]       r_state;
   logic [IDX_W-1:0] r_rk_count;
   rk_t              r_buf [0:NUM_RK-1];
   rk_t              r_win_a;
   rk_t              r_win_b;
   logic             r_rd_valid;
   rk_t              r_rd_key;
   logic             r_rd_err;
   logic             r_sched_done;

   logic             w_accept;
   logic             w_rd_gnt;
   logic [3:0]       w_rcon_idx;
   logic [7:0]       w_rcon;
   rk_t              w_new_rk;

   assign key_ready  = (r_state != ST_EXPAND);
   assign busy       = (r_state == ST_EXPAND);
   assign w_accept   = key_valid & key_ready & ~rst;

   // A read is granted only for keys already counted (or the error index),
   // and never in a key-accept cycle since the buffer is about to be replaced.
   assign w_rd_gnt   = rd_req & ~rst & ~w_accept &
                       ((rd_idx < r_rk_count) | (rd_idx >= C_NUM_RK));
   assign rd_gnt     = w_rd_gnt;

   assign w_rcon_idx = 4'(r_rk_count >> 1);
   assign w_rcon     = rcon(w_rcon_idx);

   aes256_rk_step u_step (
      .i_a    (r_win_a),
      .i_b    (r_win_b),
      .i_odd  (r_rk_count[0]),
      .i_rcon (w_rcon),
      .o_rk   (w_new_rk)
   );

   // Control FSM, round-key counter and read-response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_rk_count   <= '0;
         r_rd_valid   <= 1'b0;
         r_rd_key     <= 128'h0;
         r_rd_err     <= 1'b0;
         r_sched_done <= 1'b0;
      end else begin
         r_sched_done <= 1'b0;
         r_rd_valid   <= w_rd_gnt;
         if (w_rd_gnt) begin
            if (rd_idx >= C_NUM_RK) begin
               r_rd_key <= 128'h0;
               r_rd_err <= 1'b1;
            end else begin
               r_rd_key <= r_buf[rd_idx];
               r_rd_err <= 1'b0;
            end
         end else begin
            r_rd_key <= 128'h0;
            r_rd_err <= 1'b0;
         end
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_accept) begin
                  r_state    <= ST_EXPAND;
                  r_rk_count <= C_FIRST;
               end else begin
                  r_state    <= r_state;
               end
            end
            ST_EXPAND: begin
               if (r_rk_count == C_LAST) begin
                  r_rk_count   <= C_NUM_RK;
                  r_state      <= ST_DONE;
                  r_sched_done <= 1'b1;
               end else begin
                  r_rk_count   <= r_rk_count + 1'b1;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_rk_count <= '0;
            end
         endcase
      end
   end

   // Round-key buffer and sliding two-key window; contents need no reset
   // because validity is tracked solely by the counter.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_buf[0] <= key_in[0:127];
         r_buf[1] <= key_in[128:255];
         r_win_a  <= key_in[0:127];
         r_win_b  <= key_in[128:255];
      end else if (!rst && (r_state == ST_EXPAND)) begin
         r_buf[r_rk_count] <= w_new_rk;
         r_win_a           <= r_win_b;
         r_win_b           <= w_new_rk;
      end
   end

   assign rd_valid   = r_rd_valid;
   assign rd_key     = r_rd_key;
   assign rd_err     = r_rd_err;
   assign sched_done = r_sched_done;

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Self-checking bench: a behavioural AES-256 key-expansion model (S-box
// derived from GF(2^8) inversion) predicts every output each cycle.
module tb_aes256_key_sched_ctrl;

   logic         clk;
   logic         rst;
   logic         key_valid;
   logic         key_ready;
   logic [0:255] key_in;
   logic         rd_req;
   logic [3:0]   rd_idx;
   logic         rd_gnt;
   logic         rd_valid;
   logic [0:127] rd_key;
   logic         rd_err;
   logic         busy;
   logic         sched_done;

   aes256_key_sched_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_in     (key_in),
      .rd_req     (rd_req),
      .rd_idx     (rd_idx),
      .rd_gnt     (rd_gnt),
      .rd_valid   (rd_valid),
      .rd_key     (rd_key),
      .rd_err     (rd_err),
      .busy       (busy),
      .sched_done (sched_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [0:255] FIPS_KEY =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   int n_pass  = 0;
   int n_total = 0;

   bit [7:0] sbt [256];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
   endtask

   function automatic bit [7:0] xtime(input bit [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
      bit [7:0] r = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) r ^= a;
         a = xtime(a);
         b = b >> 1;
      end
      return r;
   endfunction

   function automatic bit [7:0] rotl8(input bit [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic bit [31:0] subw(input bit [31:0] t);
      return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
   endfunction

   // Full FIPS-197 AES-256 expansion: 60 words, round key j = words 4j..4j+3.
   function automatic logic [0:1919] expand(input logic [0:255] k);
      bit [31:0]     w [60];
      bit [31:0]     t;
      bit [7:0]      rc = 8'h01;
      logic [0:1919] r;
      for (int i = 0; i < 8; i++) w[i] = k[32*i +: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xtime(rc);
         end else if (i % 8 == 4) begin
            t = subw(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int i = 0; i < 60; i++) r[32*i +: 32] = w[i];
      return r;
   endfunction

   // Model state: number of round keys currently readable and the keys.
   int            m_avail;
   logic [0:1919] m_keys;
   bit            m_rd_valid;
   bit            m_rd_err;
   logic [0:127]  m_rd_key;
   bit            m_done;

   function automatic bit m_expanding();
      return (m_avail >= 2) && (m_avail <= 14);
   endfunction

   function automatic bit m_grant(input bit acc);
      return rd_req && ((int'(rd_idx) < m_avail) || (rd_idx == 4'd15)) && !acc;
   endfunction

   always @(posedge clk) begin
      bit acc;
      bit gnt;
      if (rst) begin
         m_avail    = 0;
         m_rd_valid = 1'b0;
         m_rd_err   = 1'b0;
         m_rd_key   = 128'h0;
         m_done     = 1'b0;
      end else begin
         acc        = key_valid && !m_expanding();
         gnt        = m_grant(acc);
         m_rd_valid = gnt;
         m_rd_err   = gnt && (rd_idx == 4'd15);
         m_rd_key   = (gnt && rd_idx != 4'd15) ? m_keys[128*int'(rd_idx) +: 128] : 128'h0;
         m_done     = (m_avail == 14);
         if (acc) begin
            m_keys  = expand(key_in);
            m_avail = 2;
         end else if (m_expanding()) begin
            m_avail = m_avail + 1;
         end
      end
   end

   always @(negedge clk) begin
      bit e_ready;
      if (!rst) begin
         e_ready = !m_expanding();
         chk("key_ready",  key_ready,  e_ready);
         chk("busy",       busy,       !e_ready);
         chk("rd_gnt",     rd_gnt,     m_grant(key_valid && e_ready));
         chk("rd_valid",   rd_valid,   m_rd_valid);
         chk("sched_done", sched_done, m_done);
         if (m_rd_valid) begin
            chk("rd_err", rd_err, m_rd_err);
            chk("rd_key", rd_key, m_rd_key);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [0:255] rnd256();
      return {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [0:1919] fk;
      logic [0:1919] zk;
      bit   [7:0]    p;
      rst = 1'b1; key_valid = 1'b0; key_in = '0; rd_req = 1'b0; rd_idx = 4'd0;

      for (int x = 0; x < 256; x++) begin
         p = 8'h01;
         for (int e = 0; e < 254; e++) p = gmul(p, 8'(x));
         sbt[x] = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
      end

      fk = expand(FIPS_KEY);
      zk = expand(256'h0);
      chk("pin_fips_rk0",  fk[0 +: 128],      128'h603deb1015ca71be2b73aef0857d7781);
      chk("pin_fips_rk2",  fk[256 +: 128],    128'h9ba354118e6925afa51a8b5f2067fcde);
      chk("pin_fips_rk14", fk[1792 +: 128],   128'hfe4890d1e6188d0b046df344706c631e);
      chk("pin_zero_rk2",  zk[256 +: 128],    128'h62636363626363636263636362636363);

      repeat (3) tick();
      rst = 1'b0;

      rd_req = 1'b1; rd_idx = 4'd3; tick();
      rd_idx = 4'd15; tick();
      rd_req = 1'b0;

      key_valid = 1'b1; key_in = FIPS_KEY; tick();
      key_valid = 1'b0; rd_req = 1'b1; rd_idx = 4'd14; tick();
      rd_idx = 4'd0; tick();
      rd_idx = 4'd14; repeat (14) tick();
      for (int i = 14; i >= 0; i--) begin
         rd_idx = 4'(i);
         tick();
      end
      rd_idx = 4'd15; tick();
      rd_req = 1'b0; tick();

      key_valid = 1'b1; key_in = rnd256(); tick();
      key_valid = 1'b0; repeat (4) tick();
      rst = 1'b1; rd_req = 1'b1; rd_idx = 4'd1; tick();
      rst = 1'b0; tick();
      rd_req = 1'b0; key_valid = 1'b1; key_in = FIPS_KEY; tick();
      key_valid = 1'b0; repeat (16) tick();

      rd_req = 1'b1; rd_idx = 4'd5; key_valid = 1'b1; key_in = 256'h0; tick();
      key_valid = 1'b0; rd_idx = 4'd2; repeat (3) tick();
      rd_idx = 4'd14; repeat (14) tick();
      rd_req = 1'b0; tick();

      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         if (!(key_valid && !key_ready)) begin
            key_valid = ($urandom_range(0, 15) == 0);
            key_in    = rnd256();
         end
         rd_req = $urandom_range(0, 1) == 1;
         rd_idx = 4'($urandom_range(0, 15));
         tick();
      end
      rst = 1'b0; key_valid = 1'b0; rd_req = 1'b0;
      repeat (2) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
